// File: rtl/mxv_result_serializer_if.sv
// Stream bundle between the matrix-by-vector engine, the result serializer and its consumer.
// Output handshake: an element transfers on a rising edge where out_valid && out_ready; while out_valid is high
// and out_ready is low, out_data/out_index/out_last hold. in_valid is a one-cycle strobe with no backpressure.
interface mxv_result_serializer_if #(
   parameter int element_width = 32,
   parameter int NI            = 8
);
   logic [NI*element_width-1:0] in_data;
   logic                        in_valid;
   logic [element_width-1:0]    out_data;
   logic                        out_valid;
   logic                        out_ready;
   logic [31:0]                 out_index;
   logic                        out_last;

   modport master (
      output in_data, in_valid, out_ready,
      input  out_data, out_valid, out_index, out_last
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output out_data, out_valid, out_index, out_last
   );
endinterface

// File: rtl/mxv_result_serializer.sv
// Buffers wide engine result words in a small FIFO and streams their elements one per cycle,
// trimming padding rows beyond `total` and flagging done after the last real element.
module mxv_result_serializer #(
   parameter int element_width = 32,
   parameter int NI            = 8,
   parameter int depth         = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic [31:0]                   total,
   mxv_result_serializer_if.slave        bus,
   output logic                          busy,
   output logic                          done,
   output logic                          overflow,
   output logic [1:0]                    dbg_state
);
   localparam int WW = NI * element_width;
   localparam int AW = $clog2(depth);
   localparam int PW = (NI > 1) ? $clog2(NI) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [31:0]     total_q, total_d;
   logic [31:0]     index_q, index_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [WW-1:0]   word_q, word_d;
   logic            ser_valid_q, ser_valid_d;
   logic [AW:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]     rd_ptr_q, rd_ptr_d;
   logic            overflow_q, overflow_d;
   logic [WW-1:0]   fifo_mem_q [depth];

   logic fifo_empty, fifo_full, in_run, out_valid_int, out_last_int;
   logic hs, ptr_wrap, finish, accept_ok, pop, push;

   always_comb begin
      fifo_empty    = (wr_ptr_q == rd_ptr_q);
      fifo_full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      in_run        = (state_q == S_RUN);
      out_valid_int = in_run && ser_valid_q && (index_q < total_q);
      out_last_int  = out_valid_int && (index_q == total_q - 32'd1);
      hs            = out_valid_int && bus.out_ready;
      ptr_wrap      = (ptr_q == PW'(NI - 1));
      finish        = hs && out_last_int;
      // A word is only considered in RUN, and never on a restart or on the final handover edge.
      accept_ok     = in_run && !start && !finish;
      pop           = accept_ok && !fifo_empty && (!ser_valid_q || (hs && ptr_wrap));
      push          = accept_ok && bus.in_valid && (!fifo_full || pop);
   end

   always_comb begin
      state_d     = state_q;
      total_d     = total_q;
      index_d     = index_q;
      ptr_d       = ptr_q;
      word_d      = word_q;
      ser_valid_d = ser_valid_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      overflow_d  = overflow_q;
      if (start) begin
         total_d     = total;
         index_d     = '0;
         ptr_d       = '0;
         ser_valid_d = 1'b0;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         overflow_d  = 1'b0;
         state_d     = (total == 32'd0) ? S_DONE : S_RUN;
      end else if (in_run) begin
         if (hs) begin
            index_d = index_q + 32'd1;
            ptr_d   = ptr_q + PW'(1);
            if (ptr_wrap) ser_valid_d = 1'b0;
         end
         if (pop) begin
            word_d      = fifo_mem_q[rd_ptr_q[AW-1:0]];
            ser_valid_d = 1'b1;
            ptr_d       = '0;
            rd_ptr_d    = rd_ptr_q + 1'b1;
         end
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         else if (accept_ok && bus.in_valid) overflow_d = 1'b1;
         // Padding left in the held word and anything still queued is discarded.
         if (finish) begin
            state_d     = S_DONE;
            ser_valid_d = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         total_q     <= '0;
         index_q     <= '0;
         ptr_q       <= '0;
         word_q      <= '0;
         ser_valid_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         total_q     <= total_d;
         index_q     <= index_d;
         ptr_q       <= ptr_d;
         word_q      <= word_d;
         ser_valid_q <= ser_valid_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= bus.in_data;
   end

   assign bus.out_valid = out_valid_int;
   assign bus.out_data  = out_valid_int ? word_q[(NI - 1 - int'(ptr_q)) * element_width +: element_width]
                                        : '0;
   assign bus.out_index = index_q;
   assign bus.out_last  = out_last_int;
   assign busy          = (state_q == S_RUN);
   assign done          = (state_q == S_DONE);
   assign overflow      = overflow_q;
   assign dbg_state     = state_q;
endmodule

// File: doc/mxv_result_serializer.md
# mxv_result_serializer

Downstream stage of the matrix-by-vector engine. Each valid strobe from the engine delivers one wide result word of NI packed elements; this block buffers the words and presents the elements one per cycle, in row order, on a valid/ready stream. The stream feeds the next iteration step (vector update / dot-product stages). The block trims the padding rows that the engine produces past the true vector length and flags `done` when the last real element has been handed over.

## Interface

**Parameters**
- `element_width`, 32, bits per result element.
- `NI`, 8, elements per engine result word.
- `depth`, 4, FIFO depth in wide words; must be a power of two, ≥ 2.

**Ports**
- `clk`  in  1  single clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; latches `total`, clears counters and FIFO, enters RUN.
- `total`  in  32  number of real elements in the result vector (excludes padding).
- `in_data`  in  NI*element_width  engine result word. Element 0 occupies the MSBs: `[NI*element_width-1 -: element_width]`.
- `in_valid`  in  1  engine read strobe (`outsider_read_now`). Upstream has no backpressure.
- `out_data`  out  element_width  current element.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the element this cycle.
- `out_index`  out  32  vector index of `out_data`, starting at 0.
- `out_last`  out  1  asserted with the element at index `total-1`.
- `busy`  out  1  high in RUN.
- `done`  out  1  level; high in DONE until the next `start` or `reset`.
- `overflow`  out  1  sticky; set when a word arrives while the FIFO is full. Cleared by `start` or `reset`.

## Operation

**State machine:** IDLE → RUN on `start`. RUN → DONE on the handshake of the element with `out_last`. DONE → RUN on `start`.
- If `total` is 0, `start` goes straight to DONE; `done` rises one cycle after `start`.
- `start` in RUN restarts: FIFO, serializer, counters and `overflow` are all cleared, and `total` is re-latched.
- `start` has priority over a simultaneous `in_valid`; that word is dropped.

**Accepting words:**
- `in_valid` is honoured only in RUN. In IDLE and DONE it is ignored, and `overflow` is not set.
- In RUN, the word is pushed if the FIFO is not full, or if a pop happens in the same cycle.
- Otherwise the word is dropped and `overflow` is set. Contents already stored are untouched.

**Serializer:**
- Holds one word plus an element pointer, 0..NI-1.
- `out_data` is element[pointer] of the held word.
- On a handshake (`out_valid && out_ready`): the pointer increments and `out_index` increments.
- When the pointer passes NI-1 and the FIFO is non-empty, the next word is popped and loaded in the same cycle, so there is no bubble.
- If the FIFO is empty at that point, `out_valid` drops until a word arrives.

**Trimming:**
- `out_valid` is never asserted for an index ≥ `total`.
- After the `out_last` handshake, the remainder of the held word (padding) and any FIFO contents are discarded.
- Words arriving in DONE are ignored.

**Stability:** while `out_valid && !out_ready`, the values of `out_data`, `out_index` and `out_last` are held constant.

**Widths:**
- `out_index` and the latched `total` are 32-bit unsigned.
- The FIFO pointers are `$clog2(depth)+1` bits wide, so that full and empty can be distinguished.

## Timing

**Reset values (cycle after `reset` sampled high):**
- State is IDLE.
- `out_data`, `out_valid`, `out_index`, `out_last`, `busy`, `done` and `overflow` are all 0.
- FIFO is empty; serializer is empty.
- `reset` mid-RUN aborts immediately; no further elements are presented.

**Timing rules:**
- **Start:** `start` at edge t gives `busy`=1 from t+1.
- **Latency:** with an empty FIFO and an empty serializer, `in_valid` at edge t gives the first element of that word with `out_valid`=1 from t+2. The word is written into the FIFO at t+1 and loaded into the serializer at t+2.
- **Throughput:** one element per cycle while `out_ready`=1. The sustained input rate must be at most one word per NI cycles, or the FIFO eventually overflows.
- **Completion:** `out_last` handshake at edge t gives `done`=1, `busy`=0 and `out_valid`=0 from t+1.

## Test plan

1. **Full words:** `total`=16, NI=8; two words with `in_valid` 8 cycles apart; `out_ready`=1. Expected: 16 elements, indices 0..15, in MSB-first order; `out_last` only at index 15; `done`=1 the next cycle; `overflow`=0.
2. **Padding trim:** `total`=13; two words whose element values equal their row numbers 0..15. Expected: values 0..12 only; `out_last` on 12; elements 13..15 never appear; `done` rises.
3. **Backpressure:** `total`=8; `out_ready` toggles 1,0,0,1,... Expected: `out_data`/`out_index` stable on every stalled cycle; all 8 elements delivered, none duplicated or skipped.
4. **Overflow:** `depth`=4; `out_ready`=0; six words on consecutive cycles. Expected: `overflow`=1 from the 6th word. After releasing `out_ready`, exactly 40 elements come out, taken from words 0..4: 4 from the FIFO plus 1 held in the serializer, in order.
5. **Edge cases:**
   - `total`=0: `done`=1 one cycle after `start`; `out_valid` never asserts.
   - Words sent in IDLE: ignored; `overflow` stays 0.
6. **Abort:**
   - `reset` asserted mid-RUN, after 3 elements: all outputs return to 0.
   - `start` asserted mid-RUN, followed by a new `total`=8 and one word: 8 fresh elements, starting at index 0.
